mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
- Sequences each access with a req/ack handshake to variable-latency memory.
- Returns read data and a per-requester stall that the hazard logic ORs into StallF/StallD/FlushE.
- Data side has fixed priority: it holds the oldest instruction in flight, so serving it first is required for forward progress.

Parameters:
- DATA_WIDTH, 32, memory data width
- ADDRESS_WIDTH, 32, memory byte-address width
- TIMEOUT_CYCLES, 16, maximum wait-for-ack cycles before a bus error; must be >= 2
- CNT_WIDTH, 5, timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
- i_CLK  in  1  clock, rising edge
- i_RST  in  1  reset, asynchronous, active-low
- i_IReq  in  1  fetch read request, held until o_IValid
- i_IAddr  in  ADDRESS_WIDTH  fetch address (PC)
- i_DReq  in  1  data access request (load or store), held until o_DValid
- i_DWe  in  1  1 = store, 0 = load
- i_DAddr  in  ADDRESS_WIDTH  data address (ALUOutM)
- i_DWData  in  DATA_WIDTH  store data (WriteDataM)
- o_IRData  out  DATA_WIDTH  instruction word
- o_IValid  out  1  one-cycle pulse: o_IRData valid
- o_DRData  out  DATA_WIDTH  load data
- o_DValid  out  1  one-cycle pulse: data access complete
- o_IStall  out  1  i_IReq & ~o_IValid
- o_DStall  out  1  i_DReq & ~o_DValid
- o_BusErr  out  1  one-cycle pulse with a Valid that ended in timeout
- o_MemReq  out  1  memory request, held until i_MemAck
- o_MemWe  out  1  memory write enable
- o_MemAddr  out  ADDRESS_WIDTH  memory address
- o_MemWData  out  DATA_WIDTH  memory write data
- i_MemRData  in  DATA_WIDTH  memory read data, valid with i_MemAck
- i_MemAck  in  1  memory completion; may arrive in the same cycle o_MemReq first rises

Behaviour:
- Reset (i_RST=0, async): state IDLE; all outputs 0 (o_IStall/o_DStall follow their own equations); timeout counter 0; latched address/data 0. Reset in any state aborts the access immediately and drops o_MemReq; a late i_MemAck after reset is ignored.
- States: IDLE, D_WAIT, I_WAIT, D_RESP, I_RESP.
- IDLE:
  - i_DReq → D_WAIT; latch i_DAddr, i_DWe, i_DWData into the o_Mem* registers and set o_MemReq=1.
  - Else i_IReq → I_WAIT; latch i_IAddr, o_MemWe=0, o_MemReq=1.
  - Both requests in the same cycle → data wins; fetch waits until IDLE is re-entered.
- D_WAIT / I_WAIT:
  - o_MemReq, o_MemAddr, o_MemWe and o_MemWData are held stable.
  - Counter increments each cycle without ack.
  - i_MemAck → capture i_MemRData (loads and fetches; stores leave o_DRData unchanged), clear o_MemReq and o_MemWe, go to D_RESP / I_RESP.
  - Counter == TIMEOUT_CYCLES-1 with no ack → clear o_MemReq, capture read data as 0, assert o_BusErr in the next state, go to the RESP state.
- D_RESP / I_RESP: o_DValid or o_IValid = 1 for exactly this cycle; requests are ignored; next state IDLE; counter cleared.
- Latency: request seen in IDLE at cycle n → o_MemReq from n+1. An ack at cycle n+k (k >= 1) → Valid at n+k+1. Minimum latency is 2 cycles.
- A new request in IDLE only while the requester's line is high. A requester must not drop its request mid-access; if it does, the access still completes and a Valid pulse is generated.
- i_MemAck while o_MemReq=0 (IDLE, RESP, or after a timeout) is ignored.
- Back-to-back: data → fetch turnaround is D_RESP → IDLE → I_WAIT, i.e. one idle cycle between memory transactions.
- Stall outputs are combinational; all other outputs are registered.

Decomposition:
- Shared package (mips_pkg): state encoding localparams (ARB_IDLE, ARB_D_WAIT, ARB_I_WAIT, ARB_D_RESP, ARB_I_RESP, 3-bit), DATA_WIDTH/ADDRESS_WIDTH defaults.
- One sub-module, arb_timeout_counter: clear, enable, terminal-count output at TIMEOUT_CYCLES-1, async active-low reset.

Test Plan:
- Fetch only, memory acks in the first cycle: i_IReq=1 at c0, i_IAddr=0x40, i_MemRData=0x20080005 → o_MemReq/o_MemAddr=0x40 at c1; o_IValid=1 and o_IRData=0x20080005 at c2; o_IStall=1 at c0–c1 and 0 at c2.
- Simultaneous requests: i_IReq and i_DReq both 1 at c0 (load, i_DAddr=0x100), ack latency 3 → data transaction first with o_DValid at c4; fetch o_MemReq rises at c6; o_IStall stays high throughout.
- Store: i_DWe=1, i_DAddr=0x8, i_DWData=0xDEADBEEF → o_MemWe=1 and o_MemWData=0xDEADBEEF held until ack; o_DValid pulse; o_DRData unchanged.
- Timeout: TIMEOUT_CYCLES=16, never ack → o_MemReq drops after 16 cycles; next cycle o_DValid=1, o_BusErr=1, o_DRData=0; a late ack two cycles later is ignored.
- Reset mid-access: i_RST low during D_WAIT → o_MemReq=0 immediately (asynchronous); after release with i_IReq=1, a fetch proceeds normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline memory-port arbiter: state encoding and default widths.
package mips_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 32;

  localparam logic [2:0] ARB_IDLE   = 3'd0;
  localparam logic [2:0] ARB_D_WAIT = 3'd1;
  localparam logic [2:0] ARB_I_WAIT = 3'd2;
  localparam logic [2:0] ARB_D_RESP = 3'd3;
  localparam logic [2:0] ARB_I_RESP = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ARB_IDLE,
    ST_D_WAIT = ARB_D_WAIT,
    ST_I_WAIT = ARB_I_WAIT,
    ST_D_RESP = ARB_D_RESP,
    ST_I_RESP = ARB_I_RESP
  } arb_state_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// Wait-for-ack cycle counter; tc flags the last cycle an access may wait before a bus error.
module arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch and data stages; data side has fixed priority.
// Handshake: o_MemReq and the o_Mem* fields stay stable until i_MemAck; one Valid pulse ends each access.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_IReq,
  input  logic [ADDRESS_WIDTH-1:0] i_IAddr,
  input  logic                     i_DReq,
  input  logic                     i_DWe,
  input  logic [ADDRESS_WIDTH-1:0] i_DAddr,
  input  logic [DATA_WIDTH-1:0]    i_DWData,
  output logic [DATA_WIDTH-1:0]    o_IRData,
  output logic                     o_IValid,
  output logic [DATA_WIDTH-1:0]    o_DRData,
  output logic                     o_DValid,
  output logic                     o_IStall,
  output logic                     o_DStall,
  output logic                     o_BusErr,
  output logic                     o_MemReq,
  output logic                     o_MemWe,
  output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
  output logic [DATA_WIDTH-1:0]    o_MemWData,
  input  logic [DATA_WIDTH-1:0]    i_MemRData,
  input  logic                     i_MemAck,
  output logic [2:0]               o_DbgState
);

  arb_state_e               state_q, state_d;
  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]    i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0]    d_rdata_q, d_rdata_d;
  logic                     i_valid_q, i_valid_d;
  logic                     d_valid_q, d_valid_d;
  logic                     bus_err_q, bus_err_d;
  logic                     waiting;
  logic                     timeout_tc;

  assign waiting = (state_q == ST_D_WAIT) || (state_q == ST_I_WAIT);

  arb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_timeout (
    .clk  (i_CLK),
    .rst_n(i_RST),
    .clr  (!waiting),
    .en   (waiting && !i_MemAck),
    .tc   (timeout_tc)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    bus_err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_DReq) begin
          state_d     = ST_D_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = i_DWe;
          mem_addr_d  = i_DAddr;
          mem_wdata_d = i_DWData;
        end else if (i_IReq) begin
          state_d    = ST_I_WAIT;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_IAddr;
        end
      end
      ST_D_WAIT: begin
        if (i_MemAck || timeout_tc) begin
          state_d   = ST_D_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_valid_d = 1'b1;
          bus_err_d = !i_MemAck;
          // Stores keep the previous load data; a timeout reads as zero.
          if (!i_MemAck)     d_rdata_d = '0;
          else if (!mem_we_q) d_rdata_d = i_MemRData;
        end
      end
      ST_I_WAIT: begin
        if (i_MemAck || timeout_tc) begin
          state_d   = ST_I_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          i_valid_d = 1'b1;
          bus_err_d = !i_MemAck;
          i_rdata_d = i_MemAck ? i_MemRData : '0;
        end
      end
      ST_D_RESP, ST_I_RESP: state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign o_IRData   = i_rdata_q;
  assign o_IValid   = i_valid_q;
  assign o_DRData   = d_rdata_q;
  assign o_DValid   = d_valid_q;
  assign o_BusErr   = bus_err_q;
  assign o_MemReq   = mem_req_q;
  assign o_MemWe    = mem_we_q;
  assign o_MemAddr  = mem_addr_q;
  assign o_MemWData = mem_wdata_q;
  assign o_IStall   = i_IReq & ~i_valid_q;
  assign o_DStall   = i_DReq & ~d_valid_q;
  assign o_DbgState = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses, a negedge monitor checks them.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_valid, d_valid, i_stall, d_stall, bus_err, mem_req, mem_we;
  logic [2:0]  dbg_state;

  // {is_data, bus_err, rdata}
  logic [33:0] exp_q[$];
  int n_checks;
  int n_errors;

  mem_port_arbiter #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
    .i_CLK(clk), .i_RST(rst_n),
    .i_IReq(i_req), .i_IAddr(i_addr),
    .i_DReq(d_req), .i_DWe(d_we), .i_DAddr(d_addr), .i_DWData(d_wdata),
    .o_IRData(i_rdata), .o_IValid(i_valid),
    .o_DRData(d_rdata), .o_DValid(d_valid),
    .o_IStall(i_stall), .o_DStall(d_stall), .o_BusErr(bus_err),
    .o_MemReq(mem_req), .o_MemWe(mem_we), .o_MemAddr(mem_addr), .o_MemWData(mem_wdata),
    .i_MemRData(mem_rdata), .i_MemAck(mem_ack),
    .o_DbgState(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (i_valid || d_valid || bus_err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got ival=%0b dval=%0b err=%0b expected none at %0t",
                 i_valid, d_valid, bus_err, $time);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("resp_kind", {30'd0, d_valid, i_valid}, e[33] ? 32'd2 : 32'd1);
        check("resp_bus_err", {31'd0, bus_err}, {31'd0, e[32]});
        check(e[33] ? "resp_d_rdata" : "resp_i_rdata", e[33] ? d_rdata : i_rdata, e[31:0]);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_memreq", {31'd0, mem_req}, 32'd0);
    check("rst_memaddr", mem_addr, 32'd0);
    check("rst_valids", {29'd0, i_valid, d_valid, bus_err}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // fetch, ack in the first wait cycle
    i_req = 1; i_addr = 32'h40; mem_rdata = 32'h2008_0005;
    exp_q.push_back({1'b0, 1'b0, 32'h2008_0005});
    settle();
    check("f_c0_istall", {31'd0, i_stall}, 32'd1);
    check("f_c0_memreq", {31'd0, mem_req}, 32'd0);
    next_cycle();
    check("f_c1_memreq", {31'd0, mem_req}, 32'd1);
    check("f_c1_memaddr", mem_addr, 32'h40);
    check("f_c1_istall", {31'd0, i_stall}, 32'd1);
    mem_ack = 1;
    next_cycle();
    mem_ack = 0;
    check("f_c2_ivalid", {31'd0, i_valid}, 32'd1);
    check("f_c2_istall", {31'd0, i_stall}, 32'd0);
    check("f_c2_memreq", {31'd0, mem_req}, 32'd0);
    i_req = 0;
    next_cycle();

    // simultaneous requests, data wins, ack latency 3
    i_req = 1; i_addr = 32'h44;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    exp_q.push_back({1'b1, 1'b0, 32'h1111_2222});
    exp_q.push_back({1'b0, 1'b0, 32'h3333_4444});
    next_cycle();
    check("s_c1_memaddr", mem_addr, 32'h100);
    check("s_c1_memwe", {31'd0, mem_we}, 32'd0);
    check("s_c1_istall", {31'd0, i_stall}, 32'd1);
    next_cycle();
    check("s_c2_memreq", {31'd0, mem_req}, 32'd1);
    next_cycle();
    mem_ack = 1; mem_rdata = 32'h1111_2222;
    next_cycle();
    mem_ack = 0;
    check("s_c4_dvalid", {31'd0, d_valid}, 32'd1);
    check("s_c4_dstall", {31'd0, d_stall}, 32'd0);
    check("s_c4_istall", {31'd0, i_stall}, 32'd1);
    d_req = 0;
    next_cycle();
    check("s_c5_memreq", {31'd0, mem_req}, 32'd0);
    check("s_c5_istall", {31'd0, i_stall}, 32'd1);
    next_cycle();
    check("s_c6_memreq", {31'd0, mem_req}, 32'd1);
    check("s_c6_memaddr", mem_addr, 32'h44);
    mem_ack = 1; mem_rdata = 32'h3333_4444;
    next_cycle();
    mem_ack = 0;
    check("s_c7_ivalid", {31'd0, i_valid}, 32'd1);
    i_req = 0;
    next_cycle();

    // store: write fields held, load data unchanged
    d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, 1'b0, 32'h1111_2222});
    next_cycle();
    for (int i = 1; i <= 3; i++) begin
      check("st_memwe", {31'd0, mem_we}, 32'd1);
      check("st_memwdata", mem_wdata, 32'hDEAD_BEEF);
      check("st_memaddr", mem_addr, 32'h8);
      if (i == 3) begin
        mem_ack = 1; mem_rdata = 32'h5555_5555;
      end
      next_cycle();
    end
    mem_ack = 0;
    check("st_dvalid", {31'd0, d_valid}, 32'd1);
    check("st_memwe_clr", {31'd0, mem_we}, 32'd0);
    d_req = 0; d_we = 0;
    next_cycle();

    // timeout: no ack for 16 cycles, then a late ack that must be ignored
    d_req = 1; d_addr = 32'h200;
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    next_cycle();
    for (int i = 1; i <= 16; i++) begin
      check("to_memreq_held", {31'd0, mem_req}, 32'd1);
      next_cycle();
    end
    check("to_memreq_drop", {31'd0, mem_req}, 32'd0);
    check("to_state_resp", {29'd0, dbg_state}, 32'd3);
    check("to_dstall", {31'd0, d_stall}, 32'd0);
    d_req = 0;
    next_cycle();
    next_cycle();
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    next_cycle();
    mem_ack = 0;
    check("to_late_state", {29'd0, dbg_state}, 32'd0);
    check("to_late_drdata", d_rdata, 32'h0);
    check("to_late_memreq", {31'd0, mem_req}, 32'd0);

    // asynchronous reset in the middle of a data access
    d_req = 1; d_addr = 32'h300;
    next_cycle();
    next_cycle();
    check("rm_memreq_before", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    settle();
    check("rm_memreq_async", {31'd0, mem_req}, 32'd0);
    check("rm_state_async", {29'd0, dbg_state}, 32'd0);
    d_req = 0;
    next_cycle();
    rst_n = 1'b1;
    mem_ack = 1;
    next_cycle();
    mem_ack = 0;
    check("rm_late_ack_state", {29'd0, dbg_state}, 32'd0);
    i_req = 1; i_addr = 32'h80; mem_rdata = 32'h0BAD_F00D;
    exp_q.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
    next_cycle();
    check("rm_f_memaddr", mem_addr, 32'h80);
    mem_ack = 1;
    next_cycle();
    mem_ack = 0;
    check("rm_f_ivalid", {31'd0, i_valid}, 32'd1);
    i_req = 0;

    repeat (3) next_cycle();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
